// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects message bytes into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
// Emits one block at a time with first/last flags for the hash core.
module sha256_msg_padder #(
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_first,
   output logic         blk_last,
   output logic         busy
);

   typedef enum logic [1:0] {FILL, PAD, EMIT, LENBLK} state_t;
   typedef enum logic [1:0] {PEND_NONE, PEND_LEN_ONLY, PEND_PAD80_LEN} pend_t;

   state_t             state_reg, state_next;
   pend_t              pend_reg, pend_next;
   logic [6:0]         idx_reg, idx_next;
   logic [LEN_W-1:0]   cnt_reg, cnt_next;
   logic               first_reg, first_next;
   logic               bfirst_reg, bfirst_next;
   logic               blast_reg, blast_next;

   logic               accept;
   logic [63:0]        len_bits;
   logic [511:0]       len_block;

   // Bytes are only taken while collecting and never while reset is asserted.
   assign in_ready  = reset && (state_reg == FILL);
   assign accept    = in_valid && in_ready;
   assign blk_valid = (state_reg == EMIT);
   assign blk_first = bfirst_reg;
   assign blk_last  = blast_reg;
   assign busy      = (state_reg != FILL) || (idx_reg != 7'd0);

   // Bit length of the message, placed in bytes 56..63 of an otherwise zero block
   // so every buffer byte can pick its length byte with a constant slice.
   assign len_bits  = 64'(cnt_reg) << 3;
   assign len_block = {448'b0, len_bits};

   // State register and control bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= FILL;
         pend_reg   <= PEND_NONE;
         idx_reg    <= 7'd0;
         cnt_reg    <= '0;
         first_reg  <= 1'b1;
         bfirst_reg <= 1'b0;
         blast_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pend_reg   <= pend_next;
         idx_reg    <= idx_next;
         cnt_reg    <= cnt_next;
         first_reg  <= first_next;
         bfirst_reg <= bfirst_next;
         blast_reg  <= blast_next;
      end
   end

   // Next-state logic: sequencing through collect, pad, emit and the extra length block.
   always_comb begin
      state_next  = state_reg;
      pend_next   = pend_reg;
      idx_next    = idx_reg;
      cnt_next    = cnt_reg;
      first_next  = first_reg;
      bfirst_next = bfirst_reg;
      blast_next  = blast_reg;
      case (state_reg)
         FILL: begin
            if (accept) begin
               idx_next = idx_reg + 7'd1;
               cnt_next = cnt_reg + 1'b1;
               if (in_last) begin
                  state_next = PAD;
               end else if (idx_reg == 7'd63) begin
                  state_next  = EMIT;
                  bfirst_next = first_reg;
                  blast_next  = 1'b0;
               end
            end
         end
         PAD: begin
            state_next  = EMIT;
            bfirst_next = first_reg;
            if (idx_reg <= 7'd55) begin
               blast_next = 1'b1;
            end else if (idx_reg <= 7'd63) begin
               blast_next = 1'b0;
               pend_next  = PEND_LEN_ONLY;
            end else begin
               blast_next = 1'b0;
               pend_next  = PEND_PAD80_LEN;
            end
         end
         EMIT: begin
            if (blk_ready) begin
               idx_next = 7'd0;
               if (pend_reg != PEND_NONE) begin
                  state_next = LENBLK;
                  first_next = 1'b0;
               end else if (blast_reg) begin
                  state_next = FILL;
                  cnt_next   = '0;
                  first_next = 1'b1;
               end else begin
                  state_next = FILL;
                  first_next = 1'b0;
               end
            end
         end
         LENBLK: begin
            pend_next   = PEND_NONE;
            state_next  = EMIT;
            bfirst_next = first_reg;
            blast_next  = 1'b1;
         end
         default: state_next = FILL;
      endcase
   end

   // One register per block byte; each byte decides its own update from idx and state.
   for (genvar gi = 0; gi < 64; gi++) begin : g_byte
      localparam logic [6:0] POS      = 7'(gi);
      localparam logic       IS_FIRST = (gi == 0);

      logic [7:0] byte_reg, byte_next;
      logic [7:0] len_byte;

      assign len_byte = len_block[511-8*gi -: 8];

      // Byte update: message data, 0x80 marker, zero fill, length, or clear after handoff.
      always_comb begin
         byte_next = byte_reg;
         case (state_reg)
            FILL: begin
               if (accept && (idx_reg == POS)) byte_next = in_data;
            end
            PAD: begin
               if (idx_reg == POS) begin
                  byte_next = 8'h80;
               end else if (idx_reg < POS) begin
                  // Length fits in this block only when the marker landed at or before byte 55.
                  byte_next = (idx_reg <= 7'd55) ? len_byte : 8'h00;
               end
            end
            EMIT: begin
               if (blk_ready) byte_next = 8'h00;
            end
            LENBLK: begin
               byte_next = (IS_FIRST && (pend_reg == PEND_PAD80_LEN)) ? 8'h80 : len_byte;
            end
            default: byte_next = byte_reg;
         endcase
      end

      // Byte storage, cleared by reset so a partial block is discarded.
      always_ff @(posedge clk) begin
         if (!reset) byte_reg <= 8'h00;
         else        byte_reg <= byte_next;
      end

      assign blk_data[511-8*gi -: 8] = byte_reg;
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder with a padding-model scoreboard.
module tb_sha256_msg_padder;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         blk_first;
   logic         blk_last;
   logic         busy;

   typedef struct {
      logic [511:0] data;
      logic         first;
      logic         last;
   } blk_t;

   blk_t       exp_q[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         n_blocks = 0;

   sha256_msg_padder #(.LEN_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_first(blk_first), .blk_last(blk_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference padding: msg, 0x80, zeros to 56 mod 64, 64-bit bit length.
   task automatic push_expected(input logic [7:0] msg[$]);
      logic [7:0]  padded[$];
      logic [63:0] bits;
      int          nb;
      blk_t        b;
      padded = msg;
      bits   = 64'(msg.size()) * 64'd8;
      padded.push_back(8'h80);
      while ((padded.size() % 64) != 56) padded.push_back(8'h00);
      for (int i = 0; i < 8; i++) padded.push_back(bits[63-8*i -: 8]);
      nb = padded.size() / 64;
      for (int bi = 0; bi < nb; bi++) begin
         b.data = '0;
         for (int k = 0; k < 64; k++) b.data[511-8*k -: 8] = padded[64*bi+k];
         b.first = (bi == 0);
         b.last  = (bi == nb - 1);
         exp_q.push_back(b);
      end
   endtask

   // Scoreboard: every handshaken block is compared with the next expected one.
   always @(negedge clk) begin
      if (blk_valid && blk_ready) begin
         blk_t e;
         n_blocks++;
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_block: observed %0h expected none", blk_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("blk%0d_data", n_blocks), blk_data, e.data);
            check($sformatf("blk%0d_first", n_blocks), 512'(blk_first), 512'(e.first));
            check($sformatf("blk%0d_last", n_blocks), 512'(blk_last), 512'(e.last));
            $display("block %0d first=%0b last=%0b w0=%08h w15=%08h", n_blocks,
                     blk_first, blk_last, blk_data[511:480], blk_data[31:0]);
         end
      end
   end

   // Called just after a posedge; returns just after the posedge that accepted the byte.
   task automatic send_byte(input logic [7:0] b, input logic last);
      int t = 0;
      in_data  = b;
      in_valid = 1'b1;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_timeout", 512'(t < 300), 512'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_msg(input logic [7:0] msg[$]);
      push_expected(msg);
      for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check(tag, 512'(exp_q.size()), 512'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]   abc[$];
      logic [7:0]   zeros[$];
      logic [511:0] abc_blk;
      int           t;

      abc     = '{8'h61, 8'h62, 8'h63};
      abc_blk = '0;
      abc_blk[511:480] = 32'h61626380;
      abc_blk[31:0]    = 32'h00000018;

      reset     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      blk_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 512'(in_ready), 512'(0));
      check("rst_blk_valid", 512'(blk_valid), 512'(0));
      check("rst_blk_data", blk_data, 512'(0));
      check("rst_flags", 512'({blk_first, blk_last}), 512'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 512'(in_ready), 512'(1));
      check("idle_busy", 512'(busy), 512'(0));
      @(posedge clk);
      #1;

      // "abc" with latency checks and a fixed expected block
      push_expected(abc);
      check("abc_model", exp_q[0].data, abc_blk);
      for (int i = 0; i < 3; i++) send_byte(abc[i], i == 2);
      @(negedge clk);
      check("abc_pad_cycle_valid", 512'(blk_valid), 512'(0));
      check("abc_pad_cycle_in_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
      check("abc_emit_valid", 512'(blk_valid), 512'(1));
      wait_drain("abc_drain");

      // 55 zero bytes: single block
      zeros = {};
      for (int i = 0; i < 55; i++) zeros.push_back(8'h00);
      send_msg(zeros);
      wait_drain("z55_drain");

      // 56 zero bytes: marker block then length-only block
      zeros.push_back(8'h00);
      send_msg(zeros);
      wait_drain("z56_drain");

      // 64 zero bytes: full block then 0x80+length block
      for (int i = 0; i < 8; i++) zeros.push_back(8'h00);
      push_expected(zeros);
      for (int i = 0; i < 64; i++) send_byte(zeros[i], i == 63);
      wait_drain("z64_drain");

      // 70 distinct bytes: spans two blocks with data in the second
      zeros = {};
      for (int i = 0; i < 70; i++) zeros.push_back(8'(i * 7 + 3));
      send_msg(zeros);
      wait_drain("m70_drain");

      // Backpressure on "abc"; in_valid held high meanwhile must be ignored
      blk_ready = 1'b0;
      push_expected(abc);
      for (int i = 0; i < 3; i++) send_byte(abc[i], i == 2);
      in_data  = 8'hEE;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!blk_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_timeout", 512'(t < 20), 512'(1));
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_valid_c%0d", c), 512'(blk_valid), 512'(1));
         check($sformatf("bp_in_ready_c%0d", c), 512'(in_ready), 512'(0));
         check($sformatf("bp_data_c%0d", c), blk_data, abc_blk);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      blk_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_after_in_ready", 512'(in_ready), 512'(1));
      check("bp_after_busy", 512'(busy), 512'(0));
      check("bp_after_valid", 512'(blk_valid), 512'(0));
      wait_drain("bp_drain");

      // Reset in the middle of a message, then "abc"
      for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 512'(in_ready), 512'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", 512'(busy), 512'(0));
      check("midrst_data", blk_data, 512'(0));
      @(posedge clk);
      #1;
      send_msg(abc);
      wait_drain("midrst_abc_drain");

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
